// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store memory port.
//   - funct3 encodings for RV32I loads and stores
//   - FSM state type
//   - access size decode, legality check and byte-mask helper
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Access size in bytes; 0 for encodings that are never legal.
  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    logic [2:0] sz;
    case (f3)
      F3_B, F3_BU: sz = 3'd1;
      F3_H, F3_HU: sz = 3'd2;
      F3_W:        sz = 3'd4;
      default:     sz = 3'd0;
    endcase
    return sz;
  endfunction

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // 8-bit mask spanning two words: low nibble for the first word, high for the second.
  function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
    logic [7:0] m;
    case (size)
      3'd1:    m = 8'h01;
      3'd2:    m = 8'h03;
      3'd4:    m = 8'h0F;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data extraction.
// Takes the two memory words of an access ({hi,lo}), the byte offset and
// funct3, and returns the sign/zero-extended 32-bit load result.
//   i_data64  in  64  {hi word, lo word}
//   i_off     in  2   byte offset of the access within the lo word
//   i_funct3  in  3   load type
//   o_rdata   out 32  extended load data
module lsu_load_align (
  input  logic [63:0] i_data64,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata
);
  import lsu_pkg::*;

  logic [31:0] w_word;

  assign w_word = 32'(i_data64 >> {i_off, 3'b000});

  always_comb begin
    o_rdata = w_word;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_word[7]}}, w_word[7:0]};
      F3_BU:   o_rdata = {24'b0, w_word[7:0]};
      F3_H:    o_rdata = {{16{w_word[15]}}, w_word[15:0]};
      F3_HU:   o_rdata = {16'b0, w_word[15:0]};
      default: o_rdata = w_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store initiator for a byte-enabled word memory.
// Accepts one request at a time over valid/ready, splits word-crossing
// accesses into two aligned word accesses and returns one response pulse.
//   clk, rst_n         clock, async active-low reset
//   req_*              request handshake and payload (we, funct3, addr, wdata)
//   resp_valid/rdata/err  one-cycle completion pulse with load data / error
//   mem_addr/be/wdata  word-aligned memory access; be nonzero only for stores
//   mem_rdata          combinational read data of the word at mem_addr
//
// state | meaning
// IDLE  | ready for a request
// ACC1  | access to the word containing the first byte
// ACC2  | access to the following word (word-crossing requests only)
// RESP  | resp_valid pulse
module lsu_mem_port #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  import lsu_pkg::*;

  lsu_state_e        r_state;
  logic              r_we;
  logic              r_err;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic              r_cross;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_wdata_hi;
  logic [31:0]       r_lo;
  logic [31:0]       r_hi;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;

  logic              w_accept;
  logic              w_legal;
  logic [2:0]        w_size;
  logic [1:0]        w_off;
  logic [7:0]        w_m8;
  logic [63:0]       w_s64;
  logic              w_cross;
  logic [31:0]       w_ld_rdata;

  assign w_accept = req_valid & r_req_ready;
  assign w_legal  = f3_legal(req_we, req_funct3);
  assign w_size   = f3_size(req_funct3);
  assign w_off    = req_addr[1:0];
  assign w_m8     = byte_mask(w_size, w_off);
  assign w_s64    = {32'b0, req_wdata} << {w_off, 3'b000};
  assign w_cross  = ({2'b00, w_off} + {1'b0, w_size}) > 4'd4;

  lsu_load_align u_load_align (
    .i_data64 ({r_hi, r_lo}),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_rdata  (w_ld_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_funct3     <= 3'b0;
      r_off        <= 2'b0;
      r_cross      <= 1'b0;
      r_be_hi      <= 4'b0;
      r_wdata_hi   <= 32'b0;
      r_lo         <= 32'b0;
      r_hi         <= 32'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= 4'b0;
      r_mem_wdata  <= 32'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_off       <= w_off;
            r_cross     <= w_cross;
            r_be_hi     <= w_m8[7:4];
            r_wdata_hi  <= w_s64[63:32];
            r_lo        <= 32'b0;
            r_hi        <= 32'b0;
            r_req_ready <= 1'b0;
            if (w_legal) begin
              r_state    <= ACC1;
              r_err      <= 1'b0;
              r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              r_mem_be   <= req_we ? w_m8[3:0] : 4'b0;
              if (req_we) r_mem_wdata <= w_s64[31:0];
            end else begin
              r_state      <= RESP;
              r_err        <= 1'b1;
              r_resp_valid <= 1'b1;
            end
          end
        end
        ACC1: begin
          if (!r_we) r_lo <= mem_rdata;
          if (r_cross) begin
            r_state    <= ACC2;
            r_mem_addr <= r_mem_addr + ADDR_W'(4);
            r_mem_be   <= r_we ? r_be_hi : 4'b0;
            if (r_we) r_mem_wdata <= r_wdata_hi;
          end else begin
            r_state      <= RESP;
            r_mem_be     <= 4'b0;
            r_resp_valid <= 1'b1;
          end
        end
        ACC2: begin
          if (!r_we) r_hi <= mem_rdata;
          r_state      <= RESP;
          r_mem_be     <= 4'b0;
          r_resp_valid <= 1'b1;
        end
        RESP: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_mem_be    <= 4'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_valid & r_err;
  // Only completed legal loads return data; stores and errors read as zero.
  assign resp_rdata = (r_resp_valid && !r_we && !r_err) ? w_ld_rdata : 32'b0;
  assign mem_addr   = r_mem_addr;
  assign mem_be     = r_mem_be;
  assign mem_wdata  = r_mem_wdata;

endmodule
